sine_sweep_ctrl: RTL and testbench
==================================

# sine_sweep_ctrl

Sequencer that drives the `phase` and `phaseStep` inputs of one `sine_wave` generator to perform a stepped frequency sweep. A configuration is latched on `start`, the generator is re-armed at the requested phase, and `phaseStep` ramps from a start value to an end value, holding each value for a programmable dwell time. Sits between the control/register layer and the sine generator datapath.

## Interface
- `PHASE_SIZE`, 8, phase/step resolution; phase and step buses are PHASE_SIZE+1 bits signed.
- `MAX_STEP`, 64, largest legal step value.
- `DWELL_W`, 16, width of the dwell count.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: reset is synchronous and active-low; outputs take reset values on the first rising edge `clock` sees with `reset`=0.
- `start` in 1: single-cycle request; sampled only in IDLE.
- `abort` in 1: terminates a sweep.
- `cfg_phase` in PHASE_SIZE+1 signed: start phase in degrees.
- `cfg_step_start`, `cfg_step_end`, `cfg_step_inc` in PHASE_SIZE+1 signed each: step range and increment.
- `cfg_dwell` in DWELL_W: cycles per step.
- `phase` out PHASE_SIZE+1 signed: to generator.
- `phaseStep` out PHASE_SIZE+1 signed: to generator.
- `gen_reset` out 1: active-high generator reset pulse.
- `busy` out 1: high in ARM and DWELL.
- `done` out 1: single-cycle completion pulse.
- `err` out 1: single-cycle configuration-rejected pulse.

## Operation
- States: IDLE, ARM, DWELL, DONE.
- IDLE: on `start`, validate cfg: 1 ≤ step_start ≤ step_end ≤ MAX_STEP, inc ≥ 1, dwell ≥ 1.
  - Valid: latch cfg, go to ARM.
  - Invalid: pulse `err`, stay in IDLE, outputs unchanged.
- `cfg_phase` is clamped to [-180, 180] on latch.
- ARM (1 cycle): `phase`=clamped phase, `phaseStep`=step_start, `gen_reset`=1, dwell counter loaded with dwell-1. Next state DWELL.
- DWELL: counter decrements each cycle. On the cycle it reads 0:
  - If the current step equals the target, go to DONE.
  - Otherwise step ← min(step+inc, target), counter reloads, and the state stays DWELL.
  - step+inc is computed at PHASE_SIZE+2 bits, so it never wraps.
- DONE (1 cycle): `done`=1, then IDLE. `phase`/`phaseStep` hold their final values, so the generator keeps running at the last step.
- `abort` in ARM/DWELL: go to IDLE on the next edge, no `done`, outputs hold.
- `start` while not in IDLE is ignored. `start` and `abort` in the same IDLE cycle: abort wins, stay IDLE.
- Reset values: `phase`=0, `phaseStep`=0, `gen_reset`=0, `busy`=0, `done`=0, `err`=0, state IDLE, counter 0. Reset mid-sweep discards the sweep immediately.

## Timing
- `start` at edge N leads to ARM in cycle N+1 (`gen_reset`, new `phase`/`phaseStep` visible) and DWELL from N+2.
- Hold times:
  - First step value: dwell+1 cycles (ARM + dwell).
  - Each later value: exactly dwell cycles.
- `done` is asserted the cycle after the final dwell expires; `busy` drops in the same cycle.
- `err` is asserted in cycle N+1 for a rejected `start` at edge N.
- All outputs are registered; no combinational input-to-output paths.

## Configuration
- `SINE_SWEEP_BIDIR_EN` defined:
  - After reaching step_end, a direction flag flips and the step descends by inc, floored at step_start.
  - DONE is entered when step_start has been held for a full dwell.
  - step_end itself is held for one dwell only, not two.
- Undefined: unidirectional up-sweep only; no direction flag is synthesised.

## Structure
- Package `sine_pkg`:
  - state enum `sweep_state_t`;
  - localparam `PHASE_W` = PHASE_SIZE+1;
  - phase clamp limits ±180;
  - default MAX_STEP.
- Sub-module `sweep_dwell_timer`: loadable down-counter with load value, `load`, `en` and a `zero` flag.
- The FSM, validation and step arithmetic live in `sine_sweep_ctrl`.

## Test plan
- phase=0, start=1, end=4, inc=1, dwell=3 → `phaseStep` 1 for 4 cycles, then 2, 3, 4 for 3 cycles each; one `gen_reset` pulse; `done` one cycle after the last dwell.
- start=2, end=7, inc=3, dwell=2 → `phaseStep` 2, 5, 7, then `done`; never 8.
- inc=0, or start=5 with end=3 → `err` pulse at N+1, `busy`=0, outputs unchanged. cfg_phase=200 with a valid cfg → `phase`=180 in ARM.
- abort in the second cycle of dwell at step 2 → `busy`=0 next cycle, no `done`, `phaseStep` stays 2. A fresh `start` then re-arms normally.
- `reset`=0 mid-DWELL → next edge all outputs 0 and state IDLE. `start` and `abort` together in IDLE → no ARM.
- With `SINE_SWEEP_BIDIR_EN`: start=1, end=3, inc=1, dwell=2 → `phaseStep` sequence 1, 2, 3, 2, 1, then `done`.

Source files
------------

// File: rtl/sine_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sine_pkg
//  Description : Shared types and constants for the sine sweep sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package sine_pkg;

    // Sweep sequencer states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_DWELL = 2'd2,
        S_DONE  = 2'd3
    } sweep_state_t;

    localparam int DEF_PHASE_SIZE  = 8;
    localparam int PHASE_W         = DEF_PHASE_SIZE + 1;
    localparam int PHASE_CLAMP_MAX = 180;
    localparam int PHASE_CLAMP_MIN = -180;
    localparam int DEF_MAX_STEP    = 64;

endpackage : sine_pkg
`default_nettype wire

// File: rtl/sweep_dwell_timer.sv
`default_nettype none
// ============================================================================
//  Module      : sweep_dwell_timer
//  Description : Loadable down-counter that stops at zero; zero flag is a
//                plain decode of the count register.
//  Revision    : 1.0  initial release
// ============================================================================
module sweep_dwell_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    // Count register: load has priority, otherwise decrement until zero
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (en && !zero) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule : sweep_dwell_timer
`default_nettype wire

// File: rtl/sine_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sine_sweep_ctrl
//  Description : Stepped frequency sweep sequencer for one sine_wave
//                generator. Latches a validated configuration on start,
//                re-arms the generator, then ramps phaseStep with a
//                programmable dwell per step.
//                Optional build macro SINE_SWEEP_BIDIR_EN adds a descending
//                leg back to the start step after reaching the end step.
//  Revision    : 1.0  initial release
// ============================================================================
module sine_sweep_ctrl
    import sine_pkg::*;
#(
    parameter int PHASE_SIZE = PHASE_W - 1,
    parameter int MAX_STEP   = DEF_MAX_STEP,
    parameter int DWELL_W    = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    input  logic signed [PHASE_SIZE:0]   cfg_phase,
    input  logic signed [PHASE_SIZE:0]   cfg_step_start,
    input  logic signed [PHASE_SIZE:0]   cfg_step_end,
    input  logic signed [PHASE_SIZE:0]   cfg_step_inc,
    input  logic        [DWELL_W-1:0]    cfg_dwell,
    output logic signed [PHASE_SIZE:0]   phase,
    output logic signed [PHASE_SIZE:0]   phaseStep,
    output logic                         gen_reset,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int PW = PHASE_SIZE + 1;
    localparam int SW = PHASE_SIZE + 2;

    localparam logic signed [PHASE_SIZE:0] C_ONE      = PW'(1);
    localparam logic signed [PHASE_SIZE:0] C_MAX_STEP = PW'(MAX_STEP);
    localparam logic signed [PHASE_SIZE:0] C_PH_MAX   = PW'(PHASE_CLAMP_MAX);
    localparam logic signed [PHASE_SIZE:0] C_PH_MIN   = PW'(PHASE_CLAMP_MIN);

    sweep_state_t                 r_state;
    sweep_state_t                 w_state_nxt;

    logic signed [PHASE_SIZE:0]   r_step_end;
    logic signed [PHASE_SIZE:0]   r_step_inc;
    logic        [DWELL_W-1:0]    r_dwell_m1;

    logic                         w_cfg_valid;
    logic signed [PHASE_SIZE:0]   w_phase_clamped;
    logic                         w_latch;
    logic                         w_reject;
    logic                         w_advance;
    logic                         w_last;
    logic signed [PHASE_SIZE:0]   w_step_next;
    logic signed [SW-1:0]         w_sum;
    logic signed [PHASE_SIZE:0]   w_step_up;

    logic                         w_tmr_zero;
    logic                         w_tmr_load;
    logic                         w_tmr_en;

    // ------------------------------------------------------------------
    // Configuration checks and request qualification
    // ------------------------------------------------------------------
    assign w_cfg_valid = (cfg_step_start >= C_ONE)
                      && (cfg_step_start <= cfg_step_end)
                      && (cfg_step_end   <= C_MAX_STEP)
                      && (cfg_step_inc   >= C_ONE)
                      && (cfg_dwell      != '0);

    // abort has priority over start even in IDLE
    assign w_latch  = (r_state == S_IDLE) && start && !abort &&  w_cfg_valid;
    assign w_reject = (r_state == S_IDLE) && start && !abort && !w_cfg_valid;

    // Dwell expired on a step that is not the final one
    assign w_advance = (r_state == S_DWELL) && !abort && w_tmr_zero && !w_last;

    // Clamp requested start phase to +/-180 degrees
    always_comb begin
        w_phase_clamped = cfg_phase;
        if (cfg_phase > C_PH_MAX) begin
            w_phase_clamped = C_PH_MAX;
        end else if (cfg_phase < C_PH_MIN) begin
            w_phase_clamped = C_PH_MIN;
        end
    end

    // Upward step, one bit wider so step+inc cannot wrap, saturated at end
    assign w_sum = $signed({phaseStep[PHASE_SIZE], phaseStep})
                 + $signed({r_step_inc[PHASE_SIZE], r_step_inc});

    always_comb begin
        w_step_up = w_sum[PHASE_SIZE:0];
        if (w_sum >= $signed({r_step_end[PHASE_SIZE], r_step_end})) begin
            w_step_up = r_step_end;
        end
    end

`ifdef SINE_SWEEP_BIDIR_EN
    logic                         r_dir;
    logic signed [PHASE_SIZE:0]   r_step_start;
    logic signed [SW-1:0]         w_diff;
    logic signed [PHASE_SIZE:0]   w_step_down;
    logic                         w_going_down;

    // Reaching the end step turns the sweep around immediately, so the end
    // value is held for a single dwell
    assign w_going_down = r_dir || (phaseStep == r_step_end);

    assign w_diff = $signed({phaseStep[PHASE_SIZE], phaseStep})
                  - $signed({r_step_inc[PHASE_SIZE], r_step_inc});

    // Downward step floored at the start step, and end-of-sweep detection
    always_comb begin
        w_step_down = w_diff[PHASE_SIZE:0];
        if (w_diff <= $signed({r_step_start[PHASE_SIZE], r_step_start})) begin
            w_step_down = r_step_start;
        end
        w_step_next = w_going_down ? w_step_down : w_step_up;
        if (r_dir) begin
            w_last = (phaseStep == r_step_start);
        end else begin
            w_last = (phaseStep == r_step_end) && (r_step_end == r_step_start);
        end
    end

    // Direction flag and floor value for the descending leg
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_dir        <= 1'b0;
            r_step_start <= '0;
        end else if (w_latch) begin
            r_dir        <= 1'b0;
            r_step_start <= cfg_step_start;
        end else if (w_advance) begin
            r_dir        <= w_going_down;
        end
    end
`else
    // Up-sweep only: finished once the end step has been dwelt on
    always_comb begin
        w_step_next = w_step_up;
        w_last      = (phaseStep == r_step_end);
    end
`endif

    // ------------------------------------------------------------------
    // Dwell timer
    // ------------------------------------------------------------------
    assign w_tmr_load = (r_state == S_ARM) || w_advance;
    assign w_tmr_en   = (r_state == S_DWELL);

    sweep_dwell_timer #(
        .WIDTH      (DWELL_W)
    ) u_dwell_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (w_tmr_load),
        .en         (w_tmr_en),
        .load_value (r_dwell_m1),
        .zero       (w_tmr_zero)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // State register
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_latch) begin
                    w_state_nxt = S_ARM;
                end
            end
            S_ARM: begin
                w_state_nxt = abort ? S_IDLE : S_DWELL;
            end
            S_DWELL: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (w_tmr_zero && w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State-decoded outputs, taken straight from the state register
    always_comb begin
        gen_reset = (r_state == S_ARM);
        busy      = (r_state == S_ARM) || (r_state == S_DWELL);
        done      = (r_state == S_DONE);
    end

    // ------------------------------------------------------------------
    // Datapath registers: latched config, generator drive, reject pulse
    // ------------------------------------------------------------------
    // Config latch on accepted start; step update when a dwell expires
    always_ff @(posedge clock) begin
        if (!reset) begin
            phase      <= '0;
            phaseStep  <= '0;
            r_step_end <= '0;
            r_step_inc <= '0;
            r_dwell_m1 <= '0;
            err        <= 1'b0;
        end else begin
            err <= w_reject;
            if (w_latch) begin
                phase      <= w_phase_clamped;
                phaseStep  <= cfg_step_start;
                r_step_end <= cfg_step_end;
                r_step_inc <= cfg_step_inc;
                r_dwell_m1 <= cfg_dwell - 1'b1;
            end else if (w_advance) begin
                phaseStep  <= w_step_next;
            end
        end
    end

endmodule : sine_sweep_ctrl
`default_nettype wire

// File: tb/tb_sine_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sine_sweep_ctrl
//  Description : Directed self-checking bench for sine_sweep_ctrl.
//                Honours SINE_SWEEP_BIDIR_EN when the design is built with it.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sine_sweep_ctrl;

    logic              clock;
    logic              reset;
    logic              start;
    logic              abort;
    logic signed [8:0] cfg_phase;
    logic signed [8:0] cfg_step_start;
    logic signed [8:0] cfg_step_end;
    logic signed [8:0] cfg_step_inc;
    logic [15:0]       cfg_dwell;
    logic signed [8:0] phase;
    logic signed [8:0] phaseStep;
    logic              gen_reset;
    logic              busy;
    logic              done;
    logic              err;

    int n_checks;
    int n_fail;
    int exp_steps[$];

    sine_sweep_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .cfg_phase      (cfg_phase),
        .cfg_step_start (cfg_step_start),
        .cfg_step_end   (cfg_step_end),
        .cfg_step_inc   (cfg_step_inc),
        .cfg_dwell      (cfg_dwell),
        .phase          (phase),
        .phaseStep      (phaseStep),
        .gen_reset      (gen_reset),
        .busy           (busy),
        .done           (done),
        .err            (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point for the whole bench
    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
        end
    endtask

    // Advance one edge and sample 1 time unit later
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Expected step sequence derived from the configuration
    function automatic void build_exp(input int s0, input int s1, input int inc);
        int s;
        exp_steps.delete();
        s = s0;
        exp_steps.push_back(s);
        while (s != s1) begin
            s = (s + inc >= s1) ? s1 : s + inc;
            exp_steps.push_back(s);
        end
`ifdef SINE_SWEEP_BIDIR_EN
        while (s != s0) begin
            s = (s - inc <= s0) ? s0 : s - inc;
            exp_steps.push_back(s);
        end
`endif
    endfunction

    task automatic issue_start(input int ph, input int s0, input int s1,
                               input int inc, input int dw);
        cfg_phase      = 9'(ph);
        cfg_step_start = 9'(s0);
        cfg_step_end   = 9'(s1);
        cfg_step_inc   = 9'(inc);
        cfg_dwell      = 16'(dw);
        start          = 1'b1;
        tick();
        start          = 1'b0;
    endtask

    // Called in the ARM cycle; follows the sweep through DONE and back to IDLE
    task automatic run_and_check(input string tag, input int dwell, input int ph);
        int gr_count;
        int hold;
        gr_count = 0;
        chk({tag, "_arm_gen_reset"}, gen_reset, 1);
        chk({tag, "_arm_phase"}, phase, ph);
        for (int i = 0; i < exp_steps.size(); i++) begin
            hold = (i == 0) ? dwell + 1 : dwell;
            for (int c = 0; c < hold; c++) begin
                chk($sformatf("%s_step%0d_c%0d", tag, i, c), phaseStep, exp_steps[i]);
                if (busy !== 1'b1) chk($sformatf("%s_busy_s%0d_c%0d", tag, i, c), busy, 1);
                if (done !== 1'b0) chk($sformatf("%s_early_done_s%0d", tag, i), done, 0);
                if (gen_reset === 1'b1) gr_count++;
                tick();
            end
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_done_busy"}, busy, 0);
        chk({tag, "_final_step"}, phaseStep, exp_steps[exp_steps.size()-1]);
        chk({tag, "_final_phase"}, phase, ph);
        chk({tag, "_gen_reset_pulses"}, gr_count, 1);
        tick();
        chk({tag, "_done_single"}, done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        reset          = 1'b0;
        start          = 1'b0;
        abort          = 1'b0;
        cfg_phase      = '0;
        cfg_step_start = '0;
        cfg_step_end   = '0;
        cfg_step_inc   = '0;
        cfg_dwell      = '0;
        tick();
        tick();
        chk("rst_phase", phase, 0);
        chk("rst_step", phaseStep, 0);
        chk("rst_gen_reset", gen_reset, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        reset = 1'b1;
        tick();

        // Basic up-sweep 1..4 step 1, dwell 3
        issue_start(0, 1, 4, 1, 3);
        build_exp(1, 4, 1);
        run_and_check("t1", 3, 0);

        // Saturating increment: 2, 5, 7 (never 8)
        issue_start(45, 2, 7, 3, 2);
        build_exp(2, 7, 3);
        run_and_check("t2", 2, 45);

        // Rejected configurations leave outputs alone
        issue_start(10, 1, 4, 0, 2);
        chk("rej_inc_err", err, 1);
        chk("rej_inc_busy", busy, 0);
        chk("rej_inc_gen_reset", gen_reset, 0);
        chk("rej_inc_step", phaseStep, exp_steps[exp_steps.size()-1]);
        chk("rej_inc_phase", phase, 45);
        tick();
        chk("rej_inc_err_single", err, 0);
        issue_start(10, 5, 3, 1, 2);
        chk("rej_order_err", err, 1);
        chk("rej_order_busy", busy, 0);
        tick();
        issue_start(10, 1, 65, 1, 2);
        chk("rej_max_err", err, 1);
        tick();
        issue_start(10, 1, 4, 1, 0);
        chk("rej_dwell_err", err, 1);
        tick();
        issue_start(10, 0, 4, 1, 1);
        chk("rej_zero_start_err", err, 1);
        chk("rej_zero_start_busy", busy, 0);
        tick();

        // Phase clamp, single-step sweep at the MAX_STEP boundary, dwell 1
        issue_start(200, 64, 64, 1, 1);
        chk("clamp_hi_err", err, 0);
        build_exp(64, 64, 1);
        run_and_check("clamp_hi", 1, 180);
        issue_start(-200, 1, 2, 5, 1);
        build_exp(1, 2, 5);
        run_and_check("clamp_lo", 1, -180);

        // Abort in the second dwell cycle at step 2
        issue_start(10, 1, 4, 1, 3);
        for (int k = 0; k < 5; k++) tick();
        chk("abort_pre_step", phaseStep, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_step", phaseStep, 2);
        chk("abort_phase", phase, 10);
        tick();
        chk("abort_done_later", done, 0);
        chk("abort_step_later", phaseStep, 2);

        // Fresh start after abort re-arms normally
        issue_start(-30, 3, 4, 1, 1);
        build_exp(3, 4, 1);
        run_and_check("rearm", 1, -30);

        // Reset mid-DWELL
        issue_start(90, 1, 4, 1, 4);
        tick();
        tick();
        chk("mid_busy_pre", busy, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("mrst_phase", phase, 0);
        chk("mrst_step", phaseStep, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_gen_reset", gen_reset, 0);
        chk("mrst_done", done, 0);
        tick();
        chk("mrst_idle_busy", busy, 0);

        // start and abort together in IDLE: no ARM
        cfg_phase      = 9'sd20;
        cfg_step_start = 9'sd1;
        cfg_step_end   = 9'sd2;
        cfg_step_inc   = 9'sd1;
        cfg_dwell      = 16'd1;
        start          = 1'b1;
        abort          = 1'b1;
        tick();
        start          = 1'b0;
        abort          = 1'b0;
        chk("sa_gen_reset", gen_reset, 0);
        chk("sa_busy", busy, 0);
        chk("sa_err", err, 0);
        chk("sa_step", phaseStep, 0);
        tick();
        chk("sa_busy_later", busy, 0);

`ifdef SINE_SWEEP_BIDIR_EN
        // Hand-written bidirectional sequence 1, 2, 3, 2, 1
        issue_start(0, 1, 3, 1, 2);
        exp_steps.delete();
        exp_steps.push_back(1);
        exp_steps.push_back(2);
        exp_steps.push_back(3);
        exp_steps.push_back(2);
        exp_steps.push_back(1);
        run_and_check("bidir", 2, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sine_sweep_ctrl
`default_nettype wire
